mem_req_arb: RTL and testbench
==============================

# mem_req_arb

Upstream requester for `mem_ctrl`. Accepts independent read and write requests from two clients (cache read-miss path, writeback path), arbitrates round-robin, and drives `mem_ctrl`'s `op`/address/data inputs. It holds each transaction stable until `tx_done`, captures read data, returns a one-cycle acknowledge to the winning client, and flags a sticky timeout error if `mem_ctrl` stalls.

## Interface
Parameters:
- `WORD_SIZE`, 512, data width; matches `mem_ctrl` WORD_SIZE.
- `ADDR_BITCOUNT`, 64, address width.
- `TIMEOUT_CYCLES`, 1024, max ISSUE cycles before `err_timeout` sets; must be ≥1.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_req`  in  1  read client request; level, held until `rd_ack`.
- `rd_addr`  in  ADDR_BITCOUNT  read address; stable while `rd_req`.
- `rd_ack`  out  1  one-cycle pulse: read complete, `rd_data` valid this cycle.
- `rd_data`  out  WORD_SIZE  captured read line; holds until next capture.
- `wr_req`  in  1  write client request; level, held until `wr_ack`.
- `wr_addr`  in  ADDR_BITCOUNT  write address; stable while `wr_req`.
- `wr_data`  in  WORD_SIZE  write line; stable while `wr_req`.
- `wr_ack`  out  1  one-cycle pulse: write complete.
- `mc_ready`  in  1  `mem_ctrl.ready`.
- `mc_tx_done`  in  1  `mem_ctrl.tx_done`.
- `mc_rd_valid`  in  1  `mem_ctrl.rd_valid`.
- `mc_rdata`  in  WORD_SIZE  `mem_ctrl.common_data_bus_write_out`.
- `mc_op`  out  2  to `mem_ctrl.op`: 00 IDLE, 01 READ, 11 WRITE.
- `mc_addr`  out  ADDR_BITCOUNT  to `mem_ctrl.raw_address`.
- `mc_wdata`  out  WORD_SIZE  to `mem_ctrl.common_data_bus_read_in`.
- `busy`  out  1  high in ISSUE or RELEASE.
- `err_timeout`  out  1  sticky timeout flag.

## Operation
- States: INIT, IDLE, ISSUE, RELEASE.
- INIT: `mc_op`=00; no grants. Move to IDLE on the first cycle `mc_ready`=1.
- IDLE: if any request is pending, grant and go to ISSUE; latch op, addr, and wdata into registers (`mc_addr`/`mc_wdata`/`mc_op` are driven only from these registers).
- Arbitration: if only one request is pending, grant it. If both are pending, grant the one not granted last (`last_grant` bit). Reset `last_grant`=WRITE, so the first contended grant is READ.
- ISSUE: `mc_op`, `mc_addr`, and `mc_wdata` are held constant. On `mc_rd_valid`=1 (read op), register `mc_rdata` into `rd_data`. On `mc_tx_done`=1, go to RELEASE.
- RELEASE: `mc_op`=00 for exactly one cycle so `mem_ctrl` returns to READY without re-launching. Pulse `rd_ack` or `wr_ack` per the op issued; update `last_grant`. Next state is IDLE.
- The client drops its req in the cycle after its ack. The arbiter does not re-sample reqs in RELEASE, so a stale req is never double-granted.
- Timeout counter: cleared on entry to ISSUE; increments each ISSUE cycle. When it reaches `TIMEOUT_CYCLES`, set `err_timeout` and saturate the counter. The transaction is not aborted; the arbiter keeps waiting for `mc_tx_done`. `err_timeout` clears only on reset.
- `mc_tx_done` or `mc_rd_valid` outside ISSUE: ignored.

## Timing
- Reset values: state=INIT, `mc_op`=00, `mc_addr`=0, `mc_wdata`=0, `rd_data`=0, `rd_ack`=0, `wr_ack`=0, `busy`=0, `err_timeout`=0, `last_grant`=WRITE, counter=0.
- Reset mid-transaction aborts immediately to INIT; outputs take reset values asynchronously.
- Request seen in IDLE at cycle N: `mc_op` is non-zero at N+1.
- `mc_tx_done` at cycle M: `mc_op`=00 and ack=1 at M+1; IDLE at M+2. Earliest next issue: `mc_op` non-zero at M+3.
- `rd_data` equals the last `mc_rdata` sampled with `mc_rd_valid` in ISSUE, and is valid when `rd_ack`=1.
- Throughput floor: 3 arbiter cycles per transaction plus `mem_ctrl` latency.

## Test plan
- Reset, then `mc_ready`=0 for 5 cycles with `rd_req`=1 -> `mc_op` stays 00. Raise `mc_ready` -> `mc_op`=01 two cycles later.
- Single read, addr 0x40: `mc_rd_valid` with `mc_rdata`=0xA5…A5, then `tx_done` -> `rd_ack` pulses once with `rd_data`=0xA5…A5; `mc_op`=00 in the ack cycle.
- Single write, addr 0x80, data 0x1234: `mc_addr`/`mc_wdata` stable through ISSUE until `tx_done` -> `wr_ack` pulse; no `rd_ack`.
- `rd_req` and `wr_req` both held for 4 transactions -> grant order R, W, R, W; the acks alternate.
- `TIMEOUT_CYCLES`=8, `tx_done` withheld for 20 cycles -> `err_timeout`=1 from ISSUE cycle 8 and stays set. A later `tx_done` completes normally, and `err_timeout` remains 1.
- Assert `rst_n`=0 mid-ISSUE -> all outputs at reset values immediately; INIT re-entered.

Source files
------------

// File: rtl/mem_req_arb.sv
// Round-robin read/write requester in front of mem_ctrl. One transaction is held
// stable until tx_done, then followed by a one-cycle RELEASE with a client ack.
`timescale 1ns/1ps

module mem_req_arb #(
  parameter int WORD_SIZE      = 512,
  parameter int ADDR_BITCOUNT  = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_req,
  input  logic [ADDR_BITCOUNT-1:0] rd_addr,
  output logic                     rd_ack,
  output logic [WORD_SIZE-1:0]     rd_data,
  input  logic                     wr_req,
  input  logic [ADDR_BITCOUNT-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0]     wr_data,
  output logic                     wr_ack,
  input  logic                     mc_ready,
  input  logic                     mc_tx_done,
  input  logic                     mc_rd_valid,
  input  logic [WORD_SIZE-1:0]     mc_rdata,
  output logic [1:0]               mc_op,
  output logic [ADDR_BITCOUNT-1:0] mc_addr,
  output logic [WORD_SIZE-1:0]     mc_wdata,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b11;

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_IDLE    = 2'd1,
    S_ISSUE   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       w_grant;
  logic                       w_grant_wr;
  logic                       r_last_grant;  // 1 = last grant went to the write client
  logic                       r_is_wr;
  logic [1:0]                 r_op;
  logic [ADDR_BITCOUNT-1:0]   r_addr;
  logic [WORD_SIZE-1:0]       r_wdata;
  logic [WORD_SIZE-1:0]       r_rd_data;
  logic                       r_rd_ack;
  logic                       r_wr_ack;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_err;

  // Requests are only looked at in IDLE, so a req still high during RELEASE is never re-granted.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_wr  = 1'b0;
    case (r_state)
      S_INIT: begin
        if (mc_ready) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (rd_req || wr_req) begin
          w_grant     = 1'b1;
          w_grant_wr  = wr_req && (!rd_req || !r_last_grant);
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mc_tx_done) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= OP_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_is_wr      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rd_ack     <= 1'b0;
      r_wr_ack     <= 1'b0;
    end else begin
      r_rd_ack <= 1'b0;
      r_wr_ack <= 1'b0;
      if (w_grant) begin
        r_op    <= w_grant_wr ? OP_WRITE : OP_READ;
        r_addr  <= w_grant_wr ? wr_addr : rd_addr;
        r_is_wr <= w_grant_wr;
        if (w_grant_wr) r_wdata <= wr_data;
      end
      // Dropping op on the tx_done edge makes RELEASE present IDLE to mem_ctrl for one cycle.
      if (r_state == S_ISSUE && mc_tx_done) begin
        r_op     <= OP_IDLE;
        r_rd_ack <= !r_is_wr;
        r_wr_ack <= r_is_wr;
      end
      if (r_state == S_RELEASE) r_last_grant <= r_is_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (r_state == S_ISSUE && mc_rd_valid && !r_is_wr) begin
      r_rd_data <= mc_rdata;
    end
  end

  // Stall watchdog: counts completed ISSUE cycles, saturates, never aborts the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
        if (r_cnt != TO_VAL) r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == TO_LAST) r_err <= 1'b1;
      end
    end
  end

  assign mc_op       = r_op;
  assign mc_addr     = r_addr;
  assign mc_wdata    = r_wdata;
  assign rd_data     = r_rd_data;
  assign rd_ack      = r_rd_ack;
  assign wr_ack      = r_wr_ack;
  assign err_timeout = r_err;
  assign busy        = (r_state == S_ISSUE) || (r_state == S_RELEASE);

endmodule

// File: tb/tb_mem_req_arb.sv
// Directed bench for mem_req_arb: a per-cycle vector table for the main flows,
// plus hand sequences for the stall watchdog and an asynchronous reset mid-ISSUE.
`timescale 1ns/1ps

module tb_mem_req_arb;

  localparam int W  = 64;
  localparam int AW = 16;
  localparam int TO = 8;
  localparam int NV = 30;

  logic          clk;
  logic          rst_n;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_ack, wr_ack;
  logic [W-1:0]  rd_data;
  logic          mc_ready, mc_tx_done, mc_rd_valid;
  logic [W-1:0]  mc_rdata;
  logic [1:0]    mc_op;
  logic [AW-1:0] mc_addr;
  logic [W-1:0]  mc_wdata;
  logic          busy, err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  mem_req_arb #(.WORD_SIZE(W), .ADDR_BITCOUNT(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mc_ready(mc_ready), .mc_tx_done(mc_tx_done), .mc_rd_valid(mc_rd_valid),
    .mc_rdata(mc_rdata), .mc_op(mc_op), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         rd, wr, rdy, td, rv;
    logic [W-1:0] rdata;
    logic [1:0]   op;
    logic         rack, wack, bsy;
    logic [AW-1:0] addr;
    logic [W-1:0] rdd;
  } vec_t;

  vec_t tv[NV];

  function automatic vec_t mk(logic rd, logic wr, logic rdy, logic td, logic rv,
                              logic [W-1:0] rdata, logic [1:0] op, logic rack,
                              logic wack, logic bsy, logic [AW-1:0] addr,
                              logic [W-1:0] rdd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rdy = rdy; v.td = td; v.rv = rv; v.rdata = rdata;
    v.op = op; v.rack = rack; v.wack = wack; v.bsy = bsy; v.addr = addr; v.rdd = rdd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " op"},     W'(mc_op),       '0);
    chk({tag, " addr"},   W'(mc_addr),     '0);
    chk({tag, " wdata"},  mc_wdata,        '0);
    chk({tag, " rddata"}, rd_data,         '0);
    chk({tag, " rdack"},  W'(rd_ack),      '0);
    chk({tag, " wrack"},  W'(wr_ack),      '0);
    chk({tag, " busy"},   W'(busy),        '0);
    chk({tag, " err"},    W'(err_timeout), '0);
  endtask

  logic [W-1:0] pa5, pff, p77, p11, p22, z;

  initial begin
    pa5 = 64'hA5A5_A5A5_A5A5_A5A5;
    pff = 64'hFFFF_FFFF_FFFF_FFFF;
    p77 = 64'h7777_7777_7777_7777;
    p11 = 64'h1111_1111_1111_1111;
    p22 = 64'h2222_2222_2222_2222;
    z   = '0;
    //            rd wr rdy td rv rdata  op    ra wa bz addr     rd_data
    for (int i = 0; i < 5; i++)
      tv[i]  = mk(1, 0, 0, 0, 0, z,   2'b00, 0, 0, 0, 16'h00, z);
    tv[5]  = mk(1, 0, 1, 0, 0, z,   2'b00, 0, 0, 0, 16'h00, z);
    tv[6]  = mk(1, 0, 1, 0, 0, z,   2'b01, 0, 0, 1, 16'h40, z);
    tv[7]  = mk(1, 0, 1, 0, 1, pa5, 2'b01, 0, 0, 1, 16'h40, pa5);
    tv[8]  = mk(1, 0, 1, 1, 0, z,   2'b00, 1, 0, 1, 16'h40, pa5);
    tv[9]  = mk(1, 0, 1, 0, 0, z,   2'b00, 0, 0, 0, 16'h40, pa5);
    tv[10] = mk(0, 0, 1, 1, 1, pff, 2'b00, 0, 0, 0, 16'h40, pa5);
    tv[11] = mk(0, 1, 1, 0, 0, z,   2'b11, 0, 0, 1, 16'h80, pa5);
    tv[12] = mk(0, 1, 1, 0, 1, p77, 2'b11, 0, 0, 1, 16'h80, pa5);
    tv[13] = mk(0, 1, 1, 0, 0, z,   2'b11, 0, 0, 1, 16'h80, pa5);
    tv[14] = mk(0, 1, 1, 1, 0, z,   2'b00, 0, 1, 1, 16'h80, pa5);
    tv[15] = mk(0, 1, 1, 0, 0, z,   2'b00, 0, 0, 0, 16'h80, pa5);
    tv[16] = mk(0, 0, 1, 0, 0, z,   2'b00, 0, 0, 0, 16'h80, pa5);
    tv[17] = mk(1, 1, 1, 0, 0, z,   2'b01, 0, 0, 1, 16'h40, pa5);
    tv[18] = mk(1, 1, 1, 1, 1, p11, 2'b00, 1, 0, 1, 16'h40, p11);
    tv[19] = mk(1, 1, 1, 0, 0, z,   2'b00, 0, 0, 0, 16'h40, p11);
    tv[20] = mk(1, 1, 1, 0, 0, z,   2'b11, 0, 0, 1, 16'h80, p11);
    tv[21] = mk(1, 1, 1, 1, 0, z,   2'b00, 0, 1, 1, 16'h80, p11);
    tv[22] = mk(1, 1, 1, 0, 0, z,   2'b00, 0, 0, 0, 16'h80, p11);
    tv[23] = mk(1, 1, 1, 0, 0, z,   2'b01, 0, 0, 1, 16'h40, p11);
    tv[24] = mk(1, 1, 1, 1, 1, p22, 2'b00, 1, 0, 1, 16'h40, p22);
    tv[25] = mk(1, 1, 1, 0, 0, z,   2'b00, 0, 0, 0, 16'h40, p22);
    tv[26] = mk(1, 1, 1, 0, 0, z,   2'b11, 0, 0, 1, 16'h80, p22);
    tv[27] = mk(1, 1, 1, 1, 0, z,   2'b00, 0, 1, 1, 16'h80, p22);
    tv[28] = mk(0, 0, 1, 0, 0, z,   2'b00, 0, 0, 0, 16'h80, p22);
    tv[29] = mk(0, 0, 1, 0, 0, z,   2'b00, 0, 0, 0, 16'h80, p22);

    rd_req = 0; wr_req = 0; mc_ready = 0; mc_tx_done = 0; mc_rd_valid = 0;
    mc_rdata = '0; rd_addr = 16'h40; wr_addr = 16'h80; wr_data = 64'h1234;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset_held");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rd_req = tv[i].rd; wr_req = tv[i].wr; mc_ready = tv[i].rdy;
      mc_tx_done = tv[i].td; mc_rd_valid = tv[i].rv; mc_rdata = tv[i].rdata;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d op", i),     W'(mc_op),       W'(tv[i].op));
      chk($sformatf("v%0d rdack", i),  W'(rd_ack),      W'(tv[i].rack));
      chk($sformatf("v%0d wrack", i),  W'(wr_ack),      W'(tv[i].wack));
      chk($sformatf("v%0d busy", i),   W'(busy),        W'(tv[i].bsy));
      chk($sformatf("v%0d addr", i),   W'(mc_addr),     W'(tv[i].addr));
      chk($sformatf("v%0d rddata", i), rd_data,         tv[i].rdd);
      chk($sformatf("v%0d err", i),    W'(err_timeout), '0);
      if (tv[i].op == 2'b11) chk($sformatf("v%0d wdata", i), mc_wdata, 64'h1234);
    end

    // Stalled read: err_timeout rises once 8 ISSUE cycles have completed and stays set.
    @(negedge clk);
    rd_req = 1; mc_tx_done = 0; mc_rd_valid = 0;
    @(posedge clk);
    #1;
    chk("to_enter op", W'(mc_op), W'(2'b01));
    chk("to_enter err", W'(err_timeout), '0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("to_k%0d err", k), W'(err_timeout), W'(k >= TO));
      chk($sformatf("to_k%0d op", k), W'(mc_op), W'(2'b01));
    end
    @(negedge clk) mc_tx_done = 1;
    @(posedge clk);
    #1;
    chk("to_done rdack", W'(rd_ack), W'(1));
    chk("to_done op", W'(mc_op), '0);
    chk("to_done err", W'(err_timeout), W'(1));
    @(negedge clk);
    mc_tx_done = 0; rd_req = 0;
    @(posedge clk);
    #1;
    chk("to_idle busy", W'(busy), '0);
    chk("to_idle err", W'(err_timeout), W'(1));

    // Asynchronous reset in the middle of a write.
    @(negedge clk) wr_req = 1;
    @(posedge clk);
    #1 chk("rst_issue op", W'(mc_op), W'(2'b11));
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1; mc_ready = 0;
    @(posedge clk);
    #1 chk("rst_init op", W'(mc_op), '0);
    chk("rst_init busy", W'(busy), '0);
    @(negedge clk) mc_ready = 1;
    @(posedge clk);
    #1 chk("rst_toidle op", W'(mc_op), '0);
    @(posedge clk);
    #1 chk("rst_regrant op", W'(mc_op), W'(2'b11));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
